// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: routes one valid/ready stream to one of four output
// channels. The destination is taken from up_sel on the first beat of a
// packet and held until the last beat. Each channel owns a one-entry
// registered buffer, so the four consumers drain independently.
module stream_demux_1_4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [1:0]         up_sel,
  input  logic               up_last,
  output logic [3:0]         down_valid,
  input  logic [3:0]         down_ready,
  output logic [4*WIDTH-1:0] down_data,
  output logic [3:0]         down_last
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]                r_state;
  logic [1:0]                r_lock_ch;
  logic [3:0]                r_valid;
  logic [3:0][WIDTH-1:0]     r_data;
  logic [3:0]                r_last;

  logic [1:0]                w_target;
  logic                      w_ready;
  logic                      w_accept;

  // Pick the destination: the locked channel mid-packet, otherwise up_sel.
  always_comb begin
    w_target = up_sel;
    case (r_state)
      ST_UNLOCKED: w_target = up_sel;
      ST_LOCKED:   w_target = r_lock_ch;
      default:     w_target = up_sel;
    endcase
  end

  // The target buffer can take a beat if it is empty or draining this cycle;
  // deliberately independent of up_valid.
  always_comb begin
    if (rst) begin
      w_ready = 1'b0;
    end else begin
      w_ready = !r_valid[w_target] || down_ready[w_target];
    end
  end

  assign w_accept = up_valid && w_ready;

  // Packet lock: taken on an accepted non-last beat, released on a last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_UNLOCKED;
      r_lock_ch <= 2'd0;
    end else if (w_accept) begin
      if (up_last) begin
        r_state <= ST_UNLOCKED;
      end else begin
        r_state   <= ST_LOCKED;
        r_lock_ch <= w_target;
      end
    end
  end

  // Per-channel buffers: a load wins over a drain, so drain+load keeps valid
  // high with the new beat; an idle stalled channel holds its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 4'b0000;
      r_data  <= '0;
      r_last  <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_accept && (w_target == 2'(k))) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= up_data;
          r_last[k]  <= up_last;
        end else if (down_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign up_ready   = w_ready;
  assign down_valid = r_valid;
  assign down_data  = r_data;
  assign down_last  = r_last;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed testbench for stream_demux_1_4 with hand-computed expectations.
module tb_stream_demux_1_4;

  logic        clk;
  logic        rst;
  logic        up_valid;
  logic        up_ready;
  logic [3:0]  up_data;
  logic [1:0]  up_sel;
  logic        up_last;
  logic [3:0]  down_valid;
  logic [3:0]  down_ready;
  logic [15:0] down_data;
  logic [3:0]  down_last;

  int n_tests;
  int n_fail;
  int n_del3;

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_sel     (up_sel),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_last  (down_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes on channel 0 carrying value 3.
  always @(posedge clk) begin
    if (!rst && down_valid[0] && down_ready[0] && down_data[3:0] == 4'h3)
      n_del3 <= n_del3 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] d, input logic [1:0] s, input logic l);
    up_valid = 1'b1;
    up_data  = d;
    up_sel   = s;
    up_last  = l;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_del3  = 0;
    rst = 1'b1;
    up_valid = 1'b1;
    up_data = 4'hF;
    up_sel = 2'd0;
    up_last = 1'b0;
    down_ready = 4'b0000;

    // Reset held two cycles with up_valid high
    tick();
    check_eq("rst_ready0", {31'd0, up_ready}, 32'd0);
    check_eq("rst_valid0", {28'd0, down_valid}, 32'd0);
    tick();
    check_eq("rst_ready1", {31'd0, up_ready}, 32'd0);
    check_eq("rst_valid1", {28'd0, down_valid}, 32'd0);
    check_eq("rst_data", {16'd0, down_data}, 32'd0);
    check_eq("rst_last", {28'd0, down_last}, 32'd0);
    rst = 1'b0;
    up_valid = 1'b0;
    tick();
    check_eq("post_rst_valid", {28'd0, down_valid}, 32'd0);

    // Single-beat routing at full throughput
    down_ready = 4'b1111;
    beat(4'hA, 2'd2, 1'b1);
    #1 check_eq("sb_ready", {31'd0, up_ready}, 32'd1);
    tick();
    check_eq("sb1_valid", {28'd0, down_valid}, 32'h4);
    check_eq("sb1_data", {28'd0, down_data[11:8]}, 32'hA);
    check_eq("sb1_last", {28'd0, down_last}, 32'h4);
    beat(4'h5, 2'd0, 1'b1);
    tick();
    check_eq("sb2_valid", {28'd0, down_valid}, 32'h1);
    check_eq("sb2_data", {28'd0, down_data[3:0]}, 32'h5);
    up_valid = 1'b0;
    tick();
    check_eq("sb_drain", {28'd0, down_valid}, 32'h0);

    // Lock: 3-beat packet stays on channel 3 despite sel changes
    beat(4'h1, 2'd3, 1'b0);
    tick();
    check_eq("lk1_valid", {28'd0, down_valid}, 32'h8);
    check_eq("lk1_data", {28'd0, down_data[15:12]}, 32'h1);
    check_eq("lk1_last", {28'd0, down_last[3]}, 32'h0);
    beat(4'h2, 2'd1, 1'b0);
    tick();
    check_eq("lk2_valid", {28'd0, down_valid}, 32'h8);
    check_eq("lk2_data", {28'd0, down_data[15:12]}, 32'h2);
    beat(4'h3, 2'd1, 1'b1);
    tick();
    check_eq("lk3_valid", {28'd0, down_valid}, 32'h8);
    check_eq("lk3_data", {28'd0, down_data[15:12]}, 32'h3);
    check_eq("lk3_last", {28'd0, down_last[3]}, 32'h1);
    beat(4'h8, 2'd1, 1'b1);
    tick();
    check_eq("unlk_valid", {28'd0, down_valid}, 32'h2);
    check_eq("unlk_data", {28'd0, down_data[7:4]}, 32'h8);
    up_valid = 1'b0;
    tick();

    // Backpressure isolation on channel 1
    down_ready = 4'b1101;
    beat(4'h7, 2'd1, 1'b1);
    #1 check_eq("bp_ready_empty", {31'd0, up_ready}, 32'd1);
    tick();
    check_eq("bp1_valid", {28'd0, down_valid}, 32'h2);
    check_eq("bp1_data", {28'd0, down_data[7:4]}, 32'h7);
    beat(4'h9, 2'd1, 1'b1);
    #1 check_eq("bp_ready_full", {31'd0, up_ready}, 32'd0);
    tick();
    check_eq("bp_hold_valid", {28'd0, down_valid}, 32'h2);
    check_eq("bp_hold_data", {28'd0, down_data[7:4]}, 32'h7);
    up_valid = 1'b0;
    #1 check_eq("bp_ready_novalid", {31'd0, up_ready}, 32'd0);
    beat(4'h9, 2'd1, 1'b1);
    tick();
    check_eq("bp_hold2_data", {28'd0, down_data[7:4]}, 32'h7);
    check_eq("bp_ch2_idle", {31'd0, down_valid[2]}, 32'd0);
    down_ready = 4'b1111;
    #1 check_eq("bp_ready_drain", {31'd0, up_ready}, 32'd1);
    tick();
    check_eq("bp2_valid", {28'd0, down_valid}, 32'h2);
    check_eq("bp2_data", {28'd0, down_data[7:4]}, 32'h9);
    beat(4'h4, 2'd2, 1'b1);
    tick();
    check_eq("bp3_valid", {28'd0, down_valid}, 32'h4);
    check_eq("bp3_data", {28'd0, down_data[11:8]}, 32'h4);
    up_valid = 1'b0;
    tick();

    // Simultaneous drain and load on channel 0
    down_ready = 4'b0000;
    n_del3 = 0;
    beat(4'h3, 2'd0, 1'b1);
    tick();
    check_eq("sdl1_valid", {28'd0, down_valid}, 32'h1);
    check_eq("sdl1_data", {28'd0, down_data[3:0]}, 32'h3);
    down_ready = 4'b0001;
    beat(4'h6, 2'd0, 1'b1);
    #1 check_eq("sdl_ready", {31'd0, up_ready}, 32'd1);
    tick();
    check_eq("sdl2_valid", {28'd0, down_valid}, 32'h1);
    check_eq("sdl2_data", {28'd0, down_data[3:0]}, 32'h6);
    up_valid = 1'b0;
    tick();
    check_eq("sdl_drain", {28'd0, down_valid}, 32'h0);
    check_eq("sdl_once", n_del3, 32'd1);

    // Reset mid-packet
    down_ready = 4'b1111;
    beat(4'h1, 2'd2, 1'b0);
    tick();
    beat(4'h2, 2'd0, 1'b0);
    tick();
    check_eq("mp_valid", {28'd0, down_valid}, 32'h4);
    check_eq("mp_data", {28'd0, down_data[11:8]}, 32'h2);
    up_valid = 1'b0;
    down_ready = 4'b0000;
    rst = 1'b1;
    tick();
    check_eq("mp_rst_valid", {28'd0, down_valid}, 32'h0);
    rst = 1'b0;
    down_ready = 4'b1111;
    beat(4'h5, 2'd1, 1'b1);
    tick();
    check_eq("mp_after_valid", {28'd0, down_valid}, 32'h2);
    check_eq("mp_after_data", {28'd0, down_data[7:4]}, 32'h5);
    up_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- 1-to-4 stream demultiplexer: the counterpart of the 4:1 data muxes; routes one upstream valid/ready stream to one of four downstream channels.
- Channel selected by up_sel at the first beat of a packet; held (locked) until the beat with up_last.
- Each output channel has a one-entry registered buffer, so the four channels drain independently.
- Sits between a single producer and four consumers in the datapath.

Parameters:
- WIDTH, 4, data width per beat in bits (must be >= 1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- up_valid  input  1  upstream beat valid.
- up_ready  output  1  upstream beat accepted when up_valid && up_ready.
- up_data  input  WIDTH  upstream beat data.
- up_sel  input  2  destination channel; sampled only on the first beat of a packet.
- up_last  input  1  final beat of packet.
- down_valid  output  4  bit k = channel k buffer holds a beat.
- down_ready  input  4  bit k = channel k consumer takes the beat.
- down_data  output  4*WIDTH  channel k data at [k*WIDTH +: WIDTH].
- down_last  output  4  bit k = buffered beat on channel k is a last beat.

Behaviour:
- Reset (rst=1 at a clk edge): down_valid=0, down_data=0, down_last=0, lock state = UNLOCKED, locked channel = 0. up_ready=0 while rst=1.
- Reset mid-packet: the lock is dropped and buffered beats are discarded (not delivered).
- State machine:
  - UNLOCKED: target t = up_sel.
  - LOCKED: target t = locked channel; up_sel ignored.
  - Transitions on an accepted beat:
    - last=0: enter/stay LOCKED with locked channel = t.
    - last=1: go to UNLOCKED.
  - No accepted beat: state unchanged.
- up_ready = !rst && (!down_valid[t] || down_ready[t]). Combinational from down_ready, up_sel and state; never depends on up_valid.
- Accept (up_valid && up_ready):
  - Next cycle: down_valid[t]=1, channel t data = up_data, down_last[t] = up_last.
  - Latency 1 cycle from acceptance to down_valid.
- Drain: down_valid[k] && down_ready[k] with no simultaneous load into k → down_valid[k]=0 next cycle. Data/last may keep their old value.
- Simultaneous drain and load of the same channel: the new beat replaces the old one, down_valid stays 1. Full throughput of 1 beat/cycle per channel when its consumer is always ready.
- Stall: while down_valid[k] && !down_ready[k], channel k data and last hold stable. Upstream stalls only if it targets k.
- Other channels: drain independently every cycle, regardless of upstream stalls or target.
- Only channel t can be loaded in a given cycle. Beats of one packet are never split across channels.
- Single-beat packet (first beat has last=1): routed by up_sel, no lock taken.
- Back-to-back packets: the beat after a last beat is routed by that cycle's up_sel with no bubble.
- up_sel/up_data/up_last changes while up_valid=0 have no effect on state.

Test Plan:
- Reset: hold rst=1 for 2 cycles with up_valid=1 → up_ready=0, down_valid=4'b0000, down_data=0. After release, down_valid stays 0 until the first accept.
- Single-beat routing: down_ready=4'b1111; send data 4'hA sel=2 last=1, then data 4'h5 sel=0 last=1 → down_valid=4'b0100 with channel 2 = A one cycle after the first accept, then down_valid=4'b0001 with channel 0 = 5 on the next cycle. Throughput is 1 beat/cycle.
- Lock: send 3-beat packet 1,2,3 with sel=3 on beat 1 and sel=1 on beats 2–3 → all three beats appear on channel 3 only, down_last[3]=1 on beat 3. The next beat with sel=1 goes to channel 1.
- Backpressure isolation: down_ready[1]=0; send beat 7 to channel 1, then beat 9 to channel 1, then beat 4 to channel 2 → channel 1 holds 7 stably and up_ready=0 for beat 9; beat 4 is not reachable until beat 9 is accepted. Raise down_ready[1] → 7 then 9 delivered; channel 2 unaffected throughout.
- Simultaneous drain/load: channel 0 full with 3, down_ready[0]=1, accept beat 6 to channel 0 in the same cycle → next cycle down_valid[0]=1 with data 6, no bubble, 3 delivered exactly once.
- Reset mid-packet: after 2 beats of a sel=2 packet (no last), assert rst for 1 cycle → all down_valid=0, state UNLOCKED. The next beat with sel=1 goes to channel 1.
